// File: rtl/fractal_sync_rr_arbiter.sv
// ============================================================================
// fractal_sync_rr_arbiter
// ----------------------------------------------------------------------------
// Registered N-in / M-out arbiter that sits between the per-port request
// queues and the fractal synchronization tree-node logic. Each cycle it hands
// up to one element per free output slot to distinct valid inputs. Inputs are
// picked either round-robin (rotating pointer) or by fixed priority (lowest
// index first). Every output slot is a register carrying valid, payload and
// the index of the input the payload came from.
//
// Parameters:
//   IN_PORTS   number of input channels (>0)
//   OUT_PORTS  number of output channels (>0)
//   DATA_W     payload width in bits (>0)
//   ARB_MODE   0 = round-robin, 1 = fixed priority (lowest index wins)
//   SRC_W      derived, width of the source tag = max(1, clog2(IN_PORTS))
//
// Ports:
//   clk_i      clock, all logic on the rising edge
//   rst_i      synchronous active-high reset
//   valid_i    per-input element valid
//   ready_o    per-input grant; the element is taken in this cycle
//   data_i     per-input payload
//   valid_o    per-output slot holds an element
//   ready_i    per-output downstream accepts the slot's element
//   data_o     per-output payload
//   src_o      per-output index of the input the element came from
// ============================================================================
module fractal_sync_rr_arbiter #(
   parameter  int IN_PORTS  = 4,
   parameter  int OUT_PORTS = 2,
   parameter  int DATA_W    = 8,
   parameter  int ARB_MODE  = 0,
   localparam int SRC_W     = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IN_PORTS-1:0]  valid_i,
   output logic [IN_PORTS-1:0]  ready_o,
   input  logic [DATA_W-1:0]    data_i [IN_PORTS],
   output logic [OUT_PORTS-1:0] valid_o,
   input  logic [OUT_PORTS-1:0] ready_i,
   output logic [DATA_W-1:0]    data_o [OUT_PORTS],
   output logic [SRC_W-1:0]     src_o  [OUT_PORTS]
);

   // Refuse to elaborate a configuration that makes no sense, so a bad
   // parameter override is caught before anyone simulates it.
   generate
      if (IN_PORTS < 1) begin : g_badInPorts
         $fatal(1, "fractal_sync_rr_arbiter: IN_PORTS must be > 0");
      end
      if (OUT_PORTS < 1) begin : g_badOutPorts
         $fatal(1, "fractal_sync_rr_arbiter: OUT_PORTS must be > 0");
      end
      if (DATA_W < 1) begin : g_badDataW
         $fatal(1, "fractal_sync_rr_arbiter: DATA_W must be > 0");
      end
      if ((ARB_MODE != 0) && (ARB_MODE != 1)) begin : g_badArbMode
         $fatal(1, "fractal_sync_rr_arbiter: ARB_MODE must be 0 or 1");
      end
   endgenerate

   logic [OUT_PORTS-1:0] r_valid;
   logic [DATA_W-1:0]    r_data [OUT_PORTS];
   logic [SRC_W-1:0]     r_src  [OUT_PORTS];
   logic [SRC_W-1:0]     r_ptr;

   logic [OUT_PORTS-1:0] w_free;
   logic [OUT_PORTS-1:0] w_fill;
   logic [DATA_W-1:0]    w_fillData [OUT_PORTS];
   logic [SRC_W-1:0]     w_fillSrc  [OUT_PORTS];
   logic [IN_PORTS-1:0]  w_ready;
   logic                 w_anyGrant;
   logic [SRC_W-1:0]     w_lastIdx;
   logic [SRC_W-1:0]     w_ptrNext;

   // A slot can take a new element when it is empty or when its current
   // element leaves this very cycle, which gives bubble-free pass-through.
   assign w_free = ~r_valid | ready_i;

   // Grant selection. Inputs are visited in search order (starting at the
   // pointer for round-robin, at 0 for fixed priority). Each valid input
   // claims the lowest free slot that nobody claimed yet; once the free slots
   // run out, later inputs are simply not granted. Since every input is
   // visited once, an input can never be granted twice in a cycle. Nothing is
   // granted while reset is held so no element is lost to the reset.
   always_comb begin
      int               startIdx;
      int               idx;
      logic [SRC_W-1:0] idxSel;
      logic             placed;

      w_fill     = '0;
      w_ready    = '0;
      w_anyGrant = 1'b0;
      w_lastIdx  = '0;
      for (int k = 0; k < OUT_PORTS; k++) begin
         w_fillData[k] = '0;
         w_fillSrc[k]  = '0;
      end

      startIdx = (ARB_MODE == 1) ? 0 : int'(r_ptr);
      idx      = 0;
      idxSel   = '0;
      placed   = 1'b0;

      for (int j = 0; j < IN_PORTS; j++) begin
         idx = startIdx + j;
         if (idx >= IN_PORTS) begin
            idx = idx - IN_PORTS;
         end
         idxSel = SRC_W'(idx);
         placed = 1'b0;
         if (valid_i[idxSel] && !rst_i) begin
            for (int k = 0; k < OUT_PORTS; k++) begin
               if (!placed && w_free[k] && !w_fill[k]) begin
                  w_fill[k]     = 1'b1;
                  w_fillData[k] = data_i[idxSel];
                  w_fillSrc[k]  = idxSel;
                  placed        = 1'b1;
               end
            end
            if (placed) begin
               w_ready[idxSel] = 1'b1;
               w_anyGrant      = 1'b1;
               w_lastIdx       = idxSel;
            end
         end
      end
   end

   // The pointer moves just past the last input granted in search order, so
   // the input that lost out this cycle is first in line next cycle. The wrap
   // is explicit because IN_PORTS need not be a power of two.
   always_comb begin
      if (int'(w_lastIdx) >= IN_PORTS - 1) begin
         w_ptrNext = '0;
      end else begin
         w_ptrNext = w_lastIdx + SRC_W'(1);
      end
   end

   // Output slot registers and the round-robin pointer. A free slot always
   // reloads: with a granted element if it got one, otherwise it goes empty.
   // A slot that is stalled by the downstream keeps its contents untouched.
   // Reset throws away whatever the slots were holding.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= '0;
         r_ptr   <= '0;
         for (int k = 0; k < OUT_PORTS; k++) begin
            r_data[k] <= '0;
            r_src[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < OUT_PORTS; k++) begin
            if (w_free[k]) begin
               r_valid[k] <= w_fill[k];
               if (w_fill[k]) begin
                  r_data[k] <= w_fillData[k];
                  r_src[k]  <= w_fillSrc[k];
               end
            end
         end
         if ((ARB_MODE == 0) && w_anyGrant) begin
            r_ptr <= w_ptrNext;
         end
      end
   end

   assign ready_o = w_ready;
   assign valid_o = r_valid;
   assign data_o  = r_data;
   assign src_o   = r_src;

endmodule

// File: doc/fractal_sync_rr_arbiter.md
# fractal_sync_rr_arbiter

Parametrised, registered N-in/M-out arbiter for fractal synchronization request/response traffic. It is the next-generation arbiter between per-port queues and the tree-node logic. It adds three things:
- valid/ready handshakes on both sides;
- selectable round-robin or fixed-priority arbitration;
- a registered output stage with backpressure.

It grants up to min(IN_PORTS, OUT_PORTS) distinct inputs per cycle and tags each output with its source index.

## Interface
Parameters:
- IN_PORTS, 4: number of input channels (>0, fatal assertion otherwise).
- OUT_PORTS, 2: number of output channels (>0, fatal assertion otherwise).
- DATA_W, 8: payload width in bits (>0).
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SRC_W, derived: max(1, $clog2(IN_PORTS)).

Ports:
- clk_i  in  1  clock; one clock domain, all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i[IN_PORTS]  in  1  input element valid.
- ready_o[IN_PORTS]  out  1  input element accepted this cycle.
- data_i[IN_PORTS]  in  DATA_W  input payload.
- valid_o[OUT_PORTS]  out  1  output register holds an element.
- ready_i[OUT_PORTS]  in  1  downstream accepts output element.
- data_o[OUT_PORTS]  out  DATA_W  output payload.
- src_o[OUT_PORTS]  out  SRC_W  index of the input the element came from.

## Operation
- Each output k owns one register holding valid, data and src.
- Slot k is free when !valid_o[k] | ready_i[k].
- Let F be the number of free slots. Each cycle the arbiter grants up to F distinct inputs with valid_i=1.
- ready_o[i]=1 exactly for the granted inputs. This is combinational from valid_i, ready_i and the pointer.
- Granted inputs fill the free slots in ascending slot index. The 1st grant goes to the lowest free k, the 2nd to the next free k, and so on.
- Unfilled free slots load valid=0. A non-free slot keeps its valid, data and src unchanged.
- Round-robin (ARB_MODE=0):
  - The search order is ptr, ptr+1, …, IN_PORTS-1, 0, …, ptr-1.
  - If at least one grant occurs, ptr <= (index of the last granted input in search order + 1) mod IN_PORTS.
  - If there are no grants, ptr holds.
- Fixed priority (ARB_MODE=1): the search always starts at 0 and ptr stays 0.
- There is no combinational path from data_i to data_o.
- src_o[k] = granted input index, registered with the data.
- Handshake rules:
  - The source must hold valid_i and data_i stable until ready_o is seen.
  - The arbiter holds valid_o, data_o and src_o stable while valid_o & !ready_i.
  - An element is transferred on a cycle where valid & ready are both high.
- OUT_PORTS > IN_PORTS is legal. At most IN_PORTS slots fill per cycle and the extra slots stay invalid.
- IN_PORTS=1: SRC_W=1, src_o is always 0, ptr is constant 0.
- A given input is never granted twice in the same cycle. Nothing is dropped or duplicated.

## Timing
- Reset (rst_i=1 sampled at a clock edge):
  - next cycle: valid_o='0, data_o='0, src_o='0, ptr=0;
  - while rst_i=1: ready_o='0.
- Reset mid-operation discards all held output elements. Elements offered during reset are not accepted.
- Latency: input accepted in cycle t, visible on data_o in cycle t+1.
- Throughput: min(IN_PORTS, OUT_PORTS) elements per cycle with no backpressure.
- A slot whose element is consumed in cycle t may be reloaded in the same cycle t (pass-through ready), so there are no bubbles.
- Fairness (round-robin): a continuously valid input is granted within ceil(IN_PORTS / number of free slots) arbitration cycles that have at least one free slot.

## Test plan
1. Reset with all valid_i=1 (IN=4, OUT=2, RR):
   - during reset, ready_o=0000;
   - cycle after release: valid_o=00, ready_o=0011, ptr then moves to 2.
2. Full throughput with all inputs valid, data 0xA0..0xA3, ready_i=11:
   - t+1: data_o[0]=A0/src0, data_o[1]=A1/src1;
   - t+2: A2/src2, A3/src3;
   - the pattern repeats with no bubbles.
3. Backpressure with ready_i[0]=0 while valid_o[0]=1 holding 0xA0:
   - data_o[0] stays 0xA0/src0;
   - exactly one ready_o per cycle, rotating 2, 3, 0 …, all loaded into slot 1.
4. Wrap-around with ptr=3, valid_i on inputs 3 and 0 only, both slots free:
   - slot0 <= in3, slot1 <= in0;
   - next ptr=1.
5. Fixed priority (ARB_MODE=1, OUT=1), inputs 0 and 3 continuously valid, ready_i=1:
   - input 0 is granted every cycle and input 3 never;
   - dropping valid_i[0] grants input 3 on the next cycle.
6. Reset mid-stream with valid_o=11 and ready_i=00, assert rst_i for one cycle:
   - next cycle valid_o=00 and ptr=0;
   - the held elements are never observed as transferred.
